// File: rtl/interrupt_context_push_if.sv
// rtl/interrupt_context_push_if.sv - data-memory port shared by the sequencer and the memory stage
interface interrupt_context_push_if #(
   parameter int ADDR_W = 16
) ();
   logic              mem_grant;
   logic [15:0]       mem_read_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write_en;
   logic [15:0]       mem_write_data;
   logic              mem_read_en;

   modport master (
      input  mem_grant, mem_read_data,
      output mem_addr, mem_write_en, mem_write_data, mem_read_en
   );

   modport slave (
      output mem_grant, mem_read_data,
      input  mem_addr, mem_write_en, mem_write_data, mem_read_en
   );
endinterface

// File: rtl/interrupt_context_push.sv
// rtl/interrupt_context_push.sv - interrupt entry: drain, push PC/flags, fetch ISR vector, redirect PC
module interrupt_context_push #(
   parameter int                ADDR_W       = 16,
   parameter int                DRAIN_CYCLES = 3,
   parameter logic [ADDR_W-1:0] VECTOR_ADDR  = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       int_req,
   input  logic [31:0]                return_pc,
   input  logic [2:0]                 flag_register,
   input  logic [ADDR_W-1:0]          sp_in,
   interrupt_context_push_if.master   mem,
   output logic [ADDR_W-1:0]          sp_out,
   output logic                       sp_write_en,
   output logic                       stall,
   output logic                       flush,
   output logic                       pc_load,
   output logic [31:0]                pc_value,
   output logic                       int_ack,
   output logic                       busy
);
   localparam int                CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DRAIN, S_PUSH_LO, S_PUSH_HI, S_PUSH_FLAGS, S_VEC_RD0, S_VEC_RD1, S_VEC_LOAD
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        pc_q;
   logic [2:0]         flags_q;
   logic [ADDR_W-1:0]  sp_q;
   logic [31:0]        pc_value_q;
   logic               hi_pending;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // hi_pending marks the single VEC_RD1 cycle in which read data belongs to the high-word read
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         pc_q       <= '0;
         flags_q    <= '0;
         sp_q       <= '0;
         pc_value_q <= '0;
         hi_pending <= 1'b0;
      end else begin
         hi_pending <= 1'b0;
         case (state)
            S_IDLE:  if (int_req) cnt <= CNT_INIT;
            S_DRAIN: begin
               if (cnt == '0) begin
                  pc_q    <= return_pc;
                  flags_q <= flag_register;
                  sp_q    <= sp_in;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_PUSH_LO, S_PUSH_HI, S_PUSH_FLAGS: if (mem.mem_grant) sp_q <= sp_q - ADDR_W'(1);
            S_VEC_RD0:  if (mem.mem_grant) hi_pending <= 1'b1;
            S_VEC_RD1:  if (hi_pending) pc_value_q[31:16] <= mem.mem_read_data;
            S_VEC_LOAD: pc_value_q[15:0] <= mem.mem_read_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (int_req)       state_nxt = S_DRAIN;
         S_DRAIN:      if (cnt == '0)     state_nxt = S_PUSH_LO;
         S_PUSH_LO:    if (mem.mem_grant) state_nxt = S_PUSH_HI;
         S_PUSH_HI:    if (mem.mem_grant) state_nxt = S_PUSH_FLAGS;
         S_PUSH_FLAGS: if (mem.mem_grant) state_nxt = S_VEC_RD0;
         S_VEC_RD0:    if (mem.mem_grant) state_nxt = S_VEC_RD1;
         S_VEC_RD1:    if (mem.mem_grant) state_nxt = S_VEC_LOAD;
         S_VEC_LOAD:                      state_nxt = S_IDLE;
         default:                         state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_addr       = '0;
      mem.mem_write_en   = 1'b0;
      mem.mem_write_data = '0;
      mem.mem_read_en    = 1'b0;
      sp_out             = '0;
      sp_write_en        = 1'b0;
      flush              = 1'b0;
      pc_load            = 1'b0;
      int_ack            = 1'b0;
      pc_value           = pc_value_q;
      busy               = (state != S_IDLE);
      stall              = (state != S_IDLE);
      case (state)
         S_PUSH_LO: begin
            mem.mem_addr       = sp_q;
            mem.mem_write_en   = mem.mem_grant;
            mem.mem_write_data = pc_q[15:0];
         end
         S_PUSH_HI: begin
            mem.mem_addr       = sp_q;
            mem.mem_write_en   = mem.mem_grant;
            mem.mem_write_data = pc_q[31:16];
         end
         S_PUSH_FLAGS: begin
            mem.mem_addr       = sp_q;
            mem.mem_write_en   = mem.mem_grant;
            mem.mem_write_data = {13'b0, flags_q};
         end
         S_VEC_RD0: begin
            mem.mem_addr    = VECTOR_ADDR;
            mem.mem_read_en = mem.mem_grant;
         end
         S_VEC_RD1: begin
            mem.mem_addr    = VECTOR_ADDR + ADDR_W'(1);
            mem.mem_read_en = mem.mem_grant;
         end
         S_VEC_LOAD: begin
            // low vector word arrives this cycle, so present the full target alongside pc_load
            pc_value    = {pc_value_q[31:16], mem.mem_read_data};
            pc_load     = 1'b1;
            flush       = 1'b1;
            int_ack     = 1'b1;
            sp_write_en = 1'b1;
            sp_out      = sp_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_interrupt_context_push.sv
// tb/tb_interrupt_context_push.sv - self-checking bench for interrupt_context_push
module tb_interrupt_context_push;
   localparam int          D = 3;
   localparam logic [15:0] V = 16'h0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        int_req;
   logic [31:0] return_pc;
   logic [2:0]  flag_register;
   logic [15:0] sp_in;
   logic [15:0] sp_out;
   logic        sp_write_en, stall, flush, pc_load, int_ack, busy;
   logic [31:0] pc_value;

   int n_tests = 0;
   int n_fail  = 0;

   interrupt_context_push_if #(.ADDR_W(16)) mif ();

   interrupt_context_push #(.ADDR_W(16), .DRAIN_CYCLES(D), .VECTOR_ADDR(V)) dut (
      .clk(clk), .rst(rst), .int_req(int_req), .return_pc(return_pc),
      .flag_register(flag_register), .sp_in(sp_in), .mem(mif),
      .sp_out(sp_out), .sp_write_en(sp_write_en), .stall(stall), .flush(flush),
      .pc_load(pc_load), .pc_value(pc_value), .int_ack(int_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   // memory model: writes logged, read data valid one cycle after read strobe, garbage otherwise
   logic [15:0] mem [0:65535];
   logic [15:0] wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   always @(posedge clk) begin
      if (mif.mem_write_en) begin
         mem[mif.mem_addr] = mif.mem_write_data;
         wr_addr_q.push_back(mif.mem_addr);
         wr_data_q.push_back(mif.mem_write_data);
      end
      if (mif.mem_read_en) mif.mem_read_data <= mem[mif.mem_addr];
      else                 mif.mem_read_data <= 16'($urandom);
   end

   function automatic logic grant_at(input logic [31:0] gmask, input int r);
      return (r <= 32) ? gmask[r-1] : 1'b1;
   endfunction

   task automatic run_seq(input string name, input logic [15:0] sp, input logic [31:0] pc,
                          input logic [2:0] fl, input logic [2:0] fl_late,
                          input logic [15:0] vhi, input logic [15:0] vlo, input logic [31:0] gmask);
      logic [15:0] exp_a [3];
      logic [15:0] exp_d [3];
      logic [15:0] m0, m1;
      logic [31:0] got_pc;
      logic [15:0] got_sp;
      int exp_rel, granted, got_rel, n_ack, n_flush, n_spw, n_pcl, busy_low;

      exp_a[0] = sp;          exp_d[0] = pc[15:0];
      exp_a[1] = sp - 16'd1;  exp_d[1] = pc[31:16];
      exp_a[2] = sp - 16'd2;  exp_d[2] = {13'b0, fl_late};
      m0 = vhi; m1 = vlo;
      for (int i = 0; i < 3; i++) begin
         if (exp_a[i] == V)          m0 = exp_d[i];
         if (exp_a[i] == 16'(V + 1)) m1 = exp_d[i];
      end
      granted = 0; exp_rel = 0;
      for (int r = D + 1; r < 64 && exp_rel == 0; r++) begin
         if (grant_at(gmask, r)) granted++;
         if (granted == 5) exp_rel = r + 1;
      end

      @(negedge clk);
      mem[V] = vhi; mem[16'(V + 1)] = vlo;
      wr_addr_q.delete(); wr_data_q.delete();
      sp_in = sp; return_pc = pc; flag_register = fl; int_req = 1'b1; mif.mem_grant = 1'b1;
      got_rel = 0; got_pc = '0; got_sp = '0;
      n_ack = 0; n_flush = 0; n_spw = 0; n_pcl = 0; busy_low = 0;
      for (int r = 1; r <= 80 && got_rel == 0; r++) begin
         @(negedge clk);
         mif.mem_grant = grant_at(gmask, r);
         if (r == D) flag_register = fl_late;
         if (r > D) begin
            return_pc = $urandom; sp_in = 16'($urandom); flag_register = 3'($urandom);
         end
         int_req = (r < exp_rel) ? 1'($urandom) : 1'b0;
         #1;
         if (!busy) busy_low++;
         n_ack += int'(int_ack); n_flush += int'(flush); n_spw += int'(sp_write_en); n_pcl += int'(pc_load);
         if (pc_load) begin got_rel = r; got_pc = pc_value; got_sp = sp_out; end
      end
      int_req = 1'b0;
      @(negedge clk); #1;
      n_ack += int'(int_ack); n_pcl += int'(pc_load);

      n_tests++; if (got_rel !== exp_rel) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, got_rel, exp_rel); end
      n_tests++; if (got_pc !== {m0, m1}) begin n_fail++; $display("FAIL %s pc_value: got %h want %h", name, got_pc, {m0, m1}); end
      n_tests++; if (got_sp !== 16'(sp - 16'd3)) begin n_fail++; $display("FAIL %s sp_out: got %h want %h", name, got_sp, 16'(sp - 16'd3)); end
      n_tests++; if (n_ack !== 1 || n_pcl !== 1 || n_flush !== 1 || n_spw !== 1) begin n_fail++; $display("FAIL %s pulse counts: ack %0d pc_load %0d flush %0d sp_we %0d want 1 each", name, n_ack, n_pcl, n_flush, n_spw); end
      n_tests++; if (busy_low !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: low-in-seq %0d after %b want 0/0", name, busy_low, busy); end
      n_tests++; if (wr_addr_q.size() !== 3) begin n_fail++; $display("FAIL %s write count: got %0d want 3", name, wr_addr_q.size()); end
      for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
         n_tests++;
         if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
            n_fail++; $display("FAIL %s write %0d: got M[%h]=%h want M[%h]=%h", name, i, wr_addr_q[i], wr_data_q[i], exp_a[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_reset;
      logic [87:0] outs;
      rst = 1'b1; int_req = 1'b0; return_pc = '0; flag_register = '0; sp_in = '0; mif.mem_grant = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      outs = {busy, stall, flush, pc_load, int_ack, sp_write_en, mif.mem_write_en, mif.mem_read_en,
              sp_out, pc_value, mif.mem_addr, mif.mem_write_data};
      n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset outputs: got %h want 0", outs); end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_push;
      logic [87:0] outs;
      int n_evt;
      @(negedge clk);
      sp_in = 16'h0800; return_pc = 32'hDEAD_BEEF; flag_register = 3'b011; int_req = 1'b1; mif.mem_grant = 1'b1;
      for (int r = 1; r <= D + 2; r++) @(negedge clk);
      rst = 1'b1; int_req = 1'b0;
      @(negedge clk); #1;
      outs = {busy, stall, flush, pc_load, int_ack, sp_write_en, mif.mem_write_en, mif.mem_read_en,
              sp_out, pc_value, mif.mem_addr, mif.mem_write_data};
      n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL rst_mid outputs: got %h want 0", outs); end
      rst = 1'b0;
      n_evt = 0;
      repeat (12) begin
         @(negedge clk); #1;
         n_evt += int'(pc_load) + int'(int_ack) + int'(busy);
      end
      n_tests++; if (n_evt !== 0) begin n_fail++; $display("FAIL rst_mid activity: got %0d events want 0", n_evt); end
      run_seq("rst_fresh", 16'h0400, 32'h0000_1000, 3'b110, 3'b110, 16'h0001, 16'h8000, '1);
   endtask

   task automatic test_request_held;
      int first, second;
      @(negedge clk);
      mem[V] = 16'h00AB; mem[16'(V + 1)] = 16'hCDEF;
      sp_in = 16'h2000; return_pc = 32'h0000_0100; flag_register = 3'b000; int_req = 1'b1; mif.mem_grant = 1'b1;
      first = 0; second = 0;
      for (int r = 1; r <= 40 && first == 0; r++) begin
         @(negedge clk); #1;
         if (pc_load) first = r;
      end
      @(negedge clk); #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held idle gap: busy %b want 0", busy); end
      @(negedge clk); #1;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held retake: busy %b want 1", busy); end
      int_req = 1'b0;
      for (int r = first + 3; r <= first + 50 && second == 0; r++) begin
         @(negedge clk); #1;
         if (pc_load) second = r;
      end
      n_tests++; if (second - first !== D + 7) begin n_fail++; $display("FAIL held second latency: got %0d want %0d", second - first, D + 7); end
      n_tests++; if (pc_value !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL held pc_value: got %h want 00abcdef", pc_value); end
      @(negedge clk); @(negedge clk); #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held final idle: busy %b want 0", busy); end
   endtask

   task automatic test_basic;
      run_seq("basic", 16'h0FFF, 32'h0001_2345, 3'b101, 3'b101, 16'h0000, 16'h0040, '1);
   endtask

   task automatic test_grant_stall;
      logic [31:0] m;
      m = ~((32'd1 << (D + 1)) | (32'd1 << (D + 2)) | (32'd1 << (D + 6)));
      run_seq("grant_stall", 16'h0FFF, 32'h0001_2345, 3'b101, 3'b101, 16'h0000, 16'h0040, m);
   endtask

   task automatic test_sp_wrap;
      run_seq("sp_wrap", 16'h0001, 32'h1234_5678, 3'b111, 3'b111, 16'h4444, 16'h5555, '1);
   endtask

   task automatic test_flag_latch;
      run_seq("flag_latch", 16'h3000, 32'h0000_0200, 3'b001, 3'b010, 16'h0002, 16'h0000, '1);
   endtask

   task automatic test_random;
      for (int k = 0; k < 6; k++)
         run_seq("random", 16'($urandom), $urandom, 3'($urandom), 3'($urandom),
                 16'($urandom), 16'($urandom), $urandom | $urandom);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_grant_stall();
      test_sp_wrap();
      test_flag_latch();
      test_reset_mid_push();
      test_request_held();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/interrupt_context_push.md
Name: interrupt_context_push

Overview:
- Interrupt entry sequencer for the 5-stage pipeline.
- On an interrupt request it stalls the front end and waits for in-flight instructions to drain. It then pushes the return PC and the 3-bit flag register {carry, negative, zero} onto the stack through the memory-stage port.
- It fetches the 32-bit ISR vector and redirects the PC.
- It is the push side of the context-restore path. RTI pops the flags word, which the execute stage consumes as conditions_from_memory_pop.

Parameters:
- ADDR_W, 16, data-memory word-address width.
- DRAIN_CYCLES, 3, cycles to wait for in-flight instructions to retire (must be ≥1).
- VECTOR_ADDR, 0, word address of the ISR vector high word; the low word is at VECTOR_ADDR+1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- int_req  input  1  level interrupt request; the source holds it until int_ack.
- return_pc  input  32  PC to resume at after RTI.
- flag_register  input  3  live flags {C,N,Z} from execute.
- sp_in  input  ADDR_W  current stack pointer.
- mem_grant  input  1  memory port free this cycle (memory stage not using it).
- mem_read_data  input  16  read data, valid one cycle after mem_read_en.
- mem_addr  output  ADDR_W  memory address.
- mem_write_en  output  1  word write strobe.
- mem_write_data  output  16  write data.
- mem_read_en  output  1  word read strobe.
- sp_out  output  ADDR_W  updated stack pointer.
- sp_write_en  output  1  one-cycle pulse committing sp_out.
- stall  output  1  freeze fetch/decode.
- flush  output  1  one-cycle pulse, kill fetch/decode contents.
- pc_load  output  1  one-cycle pulse loading pc_value.
- pc_value  output  32  ISR start address.
- int_ack  output  1  one-cycle pulse, interrupt taken.
- busy  output  1  sequencer not in IDLE.

Behaviour:
- Reset: state IDLE, all outputs 0 (including sp_out, pc_value, mem_addr, mem_write_data); drain counter 0.
- rst mid-sequence: return to IDLE next edge; no pc_load, sp_write_en or int_ack is produced; partially written stack words are abandoned.

State machine:
- IDLE: int_req sampled high → DRAIN with counter = DRAIN_CYCLES-1. int_req is sampled only in IDLE.
- DRAIN: stall=1; counter decrements each cycle. At counter 0:
  - latch return_pc and flag_register (the flags after the last retired instruction);
  - latch sp_in into local sp;
  - → PUSH_LO.
- PUSH_LO / PUSH_HI / PUSH_FLAGS:
  - Write at local sp, in this order:
    - PUSH_LO writes pc[15:0];
    - PUSH_HI writes pc[31:16];
    - PUSH_FLAGS writes {13'b0, C, N, Z}.
  - mem_write_en=1 only when mem_grant=1.
  - On a granted write: sp ← sp-1 and advance to the next state. Without grant, hold state with mem_write_en=0.
  - Resulting pop order: flags, PC high, PC low.
- VEC_RD0: when mem_grant=1, issue read at VECTOR_ADDR → VEC_RD1.
- VEC_RD1:
  - capture mem_read_data as pc_value[31:16];
  - when mem_grant=1, issue read at VECTOR_ADDR+1 → VEC_LOAD;
  - without grant, hold; the captured high word is kept.
- VEC_LOAD: capture low word into pc_value[15:0], then pulse pc_load, flush, int_ack and sp_write_en (sp_out = final sp) together → IDLE.
- stall=1 and busy=1 in every non-IDLE state.

Timing and arithmetic:
- Latency with mem_grant held at 1, int_req sampled at edge N:
  - DRAIN occupies cycles N+1..N+D;
  - pushes occupy N+D+1..N+D+3;
  - VEC_RD0 at N+D+4, VEC_RD1 at N+D+5;
  - pc_load at cycle N+D+6.
- SP arithmetic is modulo 2^ADDR_W, with wrap-around permitted.
- Outputs mem_write_en, mem_read_en and the pulses are never asserted in IDLE.

Boundary conditions:
- int_req still high in the cycle after int_ack → retaken (the source must drop it on int_ack).
- int_req toggling during a sequence has no effect.
- mem_grant=0 for arbitrary cycles stretches the sequence without corrupting it.

Test Plan:
- Basic entry, D=3, grant=1:
  - stimulus: sp_in=0x0FFF, return_pc=0x0001_2345, flags=3'b101, M[0]=0x0000, M[1]=0x0040; pulse int_req;
  - response: writes M[0FFF]=0x2345, M[0FFE]=0x0001, M[0FFD]=0x0005; pc_load with pc_value=0x0000_0040 at N+9; sp_out=0x0FFC; one int_ack/flush cycle.
- Grant stall: hold mem_grant=0 for 2 cycles during PUSH_HI and 1 during VEC_RD1 → same memory image and pc_value; pc_load delayed by exactly 3 cycles; no extra writes.
- SP wrap: sp_in=0x0001 → writes at 0x0001, 0x0000, 0xFFFF; sp_out=0xFFFE.
- Flag latch timing: change flag_register from 3'b001 to 3'b010 in the last DRAIN cycle → pushed flags word=0x0002.
- Reset mid-push: assert rst during PUSH_HI → next cycle IDLE, all outputs 0, no pc_load/int_ack. A fresh int_req then completes normally.
- Request held: keep int_req high through int_ack → second sequence starts the cycle after return to IDLE; busy low for exactly one cycle.
